// File: rtl/sram_write_checker_if.sv
// Snooped SRAM write port between the milestone mux and the SRAM controller.
// The mux side drives it (master); the checker only observes it (slave).
interface sram_write_checker_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] SRAM_address;
   logic [DATA_W-1:0] SRAM_write_data;
   logic              SRAM_we_n;

   modport master (output SRAM_address, output SRAM_write_data, output SRAM_we_n);
   modport slave  (input  SRAM_address, input  SRAM_write_data, input  SRAM_we_n);
endinterface

// File: rtl/sram_write_checker.sv
// On-chip monitor for the SRAM write port: region check, recent-duplicate detection,
// write count and CRC-32 signature of (address, data).
//
// state  | meaning
// S_IDLE | after reset, counters hold
// S_MON  | monitoring snooped writes
// S_DONE | results frozen, Pass valid
module sram_write_checker #(
   parameter int ADDR_W     = 18,
   parameter int DATA_W     = 16,
   parameter int HIST_DEPTH = 4,
   parameter int MAX_ERR    = 10
) (
   input  logic              Clock_50,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Stop,
   input  logic [ADDR_W-1:0] Region_lo,
   input  logic [ADDR_W-1:0] Region_hi,
   input  logic [ADDR_W-1:0] Expected_count,
   sram_write_checker_if.slave snoop,
   output logic              Busy,
   output logic              Done,
   output logic              Pass,
   output logic [ADDR_W-1:0] Write_count,
   output logic [31:0]       Signature,
   output logic [7:0]        OOR_count,
   output logic [7:0]        Dup_count,
   output logic              First_err_valid,
   output logic [ADDR_W-1:0] First_err_addr,
   output logic              Err_limit
);
   typedef enum logic [1:0] {S_IDLE, S_MON, S_DONE} state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_lo, r_hi, r_exp;
   logic [ADDR_W-1:0] r_wc;
   logic [31:0]       r_sig;
   logic [7:0]        r_oor, r_dup;
   logic              r_fev, r_el, r_done, r_pass;
   logic [ADDR_W-1:0] r_fea;
   logic [ADDR_W-1:0] r_hist [HIST_DEPTH];
   logic [HIST_DEPTH-1:0] r_hist_v;

   logic              w_write, w_oor, w_dup, w_err;
   logic [ADDR_W-1:0] w_wc_nxt;
   logic [7:0]        w_oor_nxt, w_dup_nxt;
   logic [31:0]       w_word, w_sig_nxt;
   logic [8:0]        w_err_sum;

   always_ff @(posedge Clock_50) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (Start)                        w_state_nxt = S_MON;
      else if (r_state == S_MON && Stop) w_state_nxt = S_DONE;
   end

   always_comb begin
      Busy = (r_state == S_MON);
   end

   // The Start cycle only relatches; its write is deliberately not observed.
   assign w_write = (r_state == S_MON) && !Start && !snoop.SRAM_we_n;
   assign w_oor   = (snoop.SRAM_address < r_lo) || (snoop.SRAM_address > r_hi);

   always_comb begin
      w_dup = 1'b0;
      for (int i = 0; i < HIST_DEPTH; i++)
         if (r_hist_v[i] && r_hist[i] == snoop.SRAM_address) w_dup = 1'b1;
   end

   assign w_err     = w_oor || w_dup;
   assign w_wc_nxt  = (w_write && r_wc != '1) ? r_wc + 1'b1 : r_wc;
   assign w_oor_nxt = (w_write && w_oor && r_oor != 8'hFF) ? r_oor + 8'd1 : r_oor;
   assign w_dup_nxt = (w_write && w_dup && r_dup != 8'hFF) ? r_dup + 8'd1 : r_dup;
   assign w_err_sum = {1'b0, w_oor_nxt} + {1'b0, w_dup_nxt};

   assign w_word    = {16'(snoop.SRAM_write_data), 16'h0000} ^ 32'(snoop.SRAM_address);
   assign w_sig_nxt = ({r_sig[30:0], 1'b0} ^ (r_sig[31] ? 32'h04C11DB7 : 32'h0)) ^ w_word;

   always_ff @(posedge Clock_50) begin
      if (Reset) begin
         r_lo <= '0; r_hi <= '0; r_exp <= '0;
         r_wc <= '0; r_sig <= 32'hFFFF_FFFF;
         r_oor <= '0; r_dup <= '0;
         r_fev <= 1'b0; r_fea <= '0; r_el <= 1'b0;
         r_done <= 1'b0; r_pass <= 1'b0;
         r_hist_v <= '0;
         for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
      end else if (Start) begin
         r_lo <= Region_lo; r_hi <= Region_hi; r_exp <= Expected_count;
         r_wc <= '0; r_sig <= 32'hFFFF_FFFF;
         r_oor <= '0; r_dup <= '0;
         r_fev <= 1'b0; r_fea <= '0; r_el <= 1'b0;
         r_done <= 1'b0; r_pass <= 1'b0;
         r_hist_v <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_write) begin
            r_wc  <= w_wc_nxt;
            r_oor <= w_oor_nxt;
            r_dup <= w_dup_nxt;
            r_sig <= w_sig_nxt;
            if (w_err && !r_fev) begin
               r_fev <= 1'b1;
               r_fea <= snoop.SRAM_address;
            end
            if (32'(w_err_sum) >= 32'(MAX_ERR)) r_el <= 1'b1;
            r_hist[0]   <= snoop.SRAM_address;
            r_hist_v[0] <= 1'b1;
            for (int i = 1; i < HIST_DEPTH; i++) begin
               r_hist[i]   <= r_hist[i-1];
               r_hist_v[i] <= r_hist_v[i-1];
            end
         end
         if (r_state == S_MON && Stop) begin
            r_done <= 1'b1;
            r_pass <= (w_oor_nxt == 8'd0) && (w_dup_nxt == 8'd0) && (w_wc_nxt == r_exp);
         end
      end
   end

   assign Done            = r_done;
   assign Pass            = r_pass;
   assign Write_count     = r_wc;
   assign Signature       = r_sig;
   assign OOR_count       = r_oor;
   assign Dup_count       = r_dup;
   assign First_err_valid = r_fev;
   assign First_err_addr  = r_fea;
   assign Err_limit       = r_el;
endmodule

// File: tb/tb_sram_write_checker.sv
// Directed bench: stimulus pushes expected run results; a monitor compares on each Done.
module tb_sram_write_checker;
   localparam int AW = 18;
   localparam int DW = 16;
   localparam logic [AW-1:0] AMAX = '1;

   logic          clk = 1'b0;
   logic          rst, start, stop;
   logic [AW-1:0] lo, hi, expc;
   logic          busy, done, pass, fev, el;
   logic [AW-1:0] wc, fea;
   logic [31:0]   sig;
   logic [7:0]    oor, dup;

   sram_write_checker_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   sram_write_checker #(.ADDR_W(AW), .DATA_W(DW), .HIST_DEPTH(4), .MAX_ERR(10)) dut (
      .Clock_50(clk), .Reset(rst), .Start(start), .Stop(stop),
      .Region_lo(lo), .Region_hi(hi), .Expected_count(expc),
      .snoop(bus),
      .Busy(busy), .Done(done), .Pass(pass), .Write_count(wc), .Signature(sig),
      .OOR_count(oor), .Dup_count(dup), .First_err_valid(fev), .First_err_addr(fea),
      .Err_limit(el)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          pass;
      logic [AW-1:0] wc;
      logic [7:0]    oor;
      logic [7:0]    dup;
      logic          fev;
      logic [AW-1:0] fea;
      logic          el;
      logic [31:0]   sig;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] m_sig;
   logic        prev_done = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] crc(input logic [31:0] s, input logic [AW-1:0] a,
                                       input logic [DW-1:0] d);
      logic [31:0] w;
      w = {d, 16'h0000} ^ {14'h0, a};
      return ({s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0)) ^ w;
   endfunction

   function automatic exp_t mk(input logic p, input int wcnt, input int o, input int dp,
                               input logic fv, input int fa, input logic e);
      exp_t r;
      r.pass = p; r.wc = AW'(wcnt); r.oor = 8'(o); r.dup = 8'(dp);
      r.fev = fv; r.fea = AW'(fa); r.el = e; r.sig = 32'h0;
      return r;
   endfunction

   task automatic cyc(input logic s, input logic p, input logic w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
      start = s; stop = p; bus.SRAM_we_n = !w; bus.SRAM_address = a; bus.SRAM_write_data = d;
      @(negedge clk);
      start = 1'b0; stop = 1'b0; bus.SRAM_we_n = 1'b1;
   endtask

   task automatic do_start(input logic [AW-1:0] l, input logic [AW-1:0] h, input int e);
      lo = l; hi = h; expc = AW'(e);
      cyc(1'b1, 1'b0, 1'b0, '0, '0);
      m_sig = 32'hFFFF_FFFF;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      cyc(1'b0, 1'b0, 1'b1, a, d);
      m_sig = crc(m_sig, a, d);
   endtask

   task automatic do_stop(input exp_t e, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      if (w) m_sig = crc(m_sig, a, d);
      e.sig = m_sig;
      sb.push_back(e);
      cyc(1'b0, 1'b1, w, a, d);
      cyc(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (prev_done) chk("done_pulse_width", done, 1'b0);
      if (!rst && done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done actual=1 required=0");
         end else begin
            e = sb.pop_front();
            chk("pass",      pass, e.pass);
            chk("wcount",    wc,   e.wc);
            chk("oor",       oor,  e.oor);
            chk("dup",       dup,  e.dup);
            chk("ferr_v",    fev,  e.fev);
            chk("ferr_addr", fea,  e.fea);
            chk("err_limit", el,   e.el);
            chk("signature", sig,  e.sig);
            chk("busy_done", busy, 1'b0);
         end
      end
      prev_done = (done === 1'b1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; lo = '0; hi = '0; expc = '0;
      bus.SRAM_we_n = 1'b1; bus.SRAM_address = '0; bus.SRAM_write_data = '0;
      m_sig = 32'hFFFF_FFFF;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pass", pass, 0);
      chk("rst_wc", wc, 0); chk("rst_sig", sig, 32'hFFFF_FFFF); chk("rst_oor", oor, 0);
      chk("rst_dup", dup, 0); chk("rst_fev", fev, 0); chk("rst_fea", fea, 0);
      chk("rst_el", el, 0);
      rst = 1'b0;

      cyc(1'b0, 1'b1, 1'b0, '0, '0);
      chk("stop_in_idle", busy, 0);

      do_start(18'd146944, 18'd262143, 4);
      chk("busy_mon", busy, 1);
      for (int i = 0; i < 4; i++) wr(AW'(146944 + i), DW'(16'hA000 + i));
      do_stop(mk(1, 4, 0, 0, 0, 0, 0), 1'b0, '0, '0);
      chk("pass_held", pass, 1);

      do_start(18'd146944, 18'd262143, 4);
      wr(18'd146944, 16'h1); wr(18'd100, 16'h2); wr(18'd146945, 16'h3); wr(18'd146946, 16'h4);
      do_stop(mk(0, 4, 1, 0, 1, 100, 0), 1'b0, '0, '0);

      do_start('0, AMAX, 3);
      wr(18'd10, 16'h1); wr(18'd20, 16'h2); wr(18'd10, 16'h3);
      do_stop(mk(0, 3, 0, 1, 1, 10, 0), 1'b0, '0, '0);

      do_start('0, AMAX, 6);
      wr(18'd10, 16'h1); wr(18'd20, 16'h2); wr(18'd30, 16'h3);
      wr(18'd40, 16'h4); wr(18'd50, 16'h5); wr(18'd10, 16'h6);
      do_stop(mk(1, 6, 0, 0, 0, 0, 0), 1'b0, '0, '0);

      do_start(18'd100, 18'd50, 1);
      wr(18'd70, 16'h7);
      do_stop(mk(0, 1, 1, 0, 1, 70, 0), 1'b0, '0, '0);

      do_start(18'd1000, 18'd2000, 300);
      for (int i = 0; i < 300; i++) begin
         wr(AW'(i), DW'(i));
         if (i == 8)   chk("el_after_9", el, 0);
         if (i == 9)   chk("el_after_10", el, 1);
         if (i == 150) chk("el_sticky", el, 1);
      end
      do_stop(mk(0, 300, 255, 0, 1, 0, 1), 1'b0, '0, '0);

      lo = '0; hi = AMAX; expc = 18'd2;
      cyc(1'b1, 1'b0, 1'b1, 18'd5, 16'h55);
      m_sig = 32'hFFFF_FFFF;
      chk("start_write_ignored", wc, 0);
      wr(18'd6, 16'h66);
      do_stop(mk(1, 2, 0, 0, 0, 0, 0), 1'b1, 18'd7, 16'h77);

      expc = 18'd0;
      cyc(1'b1, 1'b1, 1'b0, '0, '0);
      m_sig = 32'hFFFF_FFFF;
      chk("start_stop_mon", busy, 1);
      do_stop(mk(1, 0, 0, 0, 0, 0, 0), 1'b0, '0, '0);

      do_start('0, AMAX, 3);
      wr(18'd1, 16'h1); wr(18'd2, 16'h2); wr(18'd3, 16'h3);
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, '0, '0);
      rst = 1'b0;
      chk("midrst_busy", busy, 0); chk("midrst_wc", wc, 0);
      chk("midrst_sig", sig, 32'hFFFF_FFFF); chk("midrst_fev", fev, 0);

      do_start('0, AMAX, 1);
      wr(18'd0, 16'h1234);
      chk("sig_ref_1234", sig, 32'hE90A_E249);
      do_stop(mk(1, 1, 0, 0, 0, 0, 0), 1'b0, '0, '0);

      repeat (3) @(negedge clk);
      chk("sb_drain", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
